// File: rtl/icache_param.sv
// Parameterised set-associative instruction cache: flop-array tag/valid/data
// storage with tree-PLRU replacement, 0-cycle hits, AXI burst refill,
// uncached single-beat fetch and index/hit invalidate maintenance ops.

// Per-way tag comparator, instantiated once per way for fetch and maintenance.
module icache_way_cmp #(
  parameter int TW = 20
) (
  input  logic          valid,
  input  logic [TW-1:0] tag_stored,
  input  logic [TW-1:0] tag_in,
  output logic          hit
);
  assign hit = valid && (tag_stored == tag_in);
endmodule

module icache_param #(
  parameter int INDEX_WIDTH  = 7,
  parameter int OFFSET_WIDTH = 5,
  parameter int WAYS         = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_en,
  input  logic [31:0] pc,
  input  logic        no_cache,
  input  logic        cop_en,
  input  logic        cop_type,
  input  logic [31:0] cop_addr,
  output logic [31:0] inst_rdata,
  output logic        stall,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  input  logic        rlast,
  output logic        rready
);
  localparam int SETS = 1 << INDEX_WIDTH;
  localparam int WW   = OFFSET_WIDTH - 2;          // word-in-line index width
  localparam int WPL  = 1 << WW;                   // words per line
  localparam int TW   = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int LVL  = $clog2(WAYS);              // PLRU tree depth
  localparam int LW   = (WAYS > 1) ? LVL : 1;      // way index width
  localparam int PW   = (WAYS > 1) ? WAYS - 1 : 1; // PLRU bits per set

  typedef enum logic [2:0] {LOOKUP, REFILL_AR, REFILL_R, UNC_AR, UNC_R, RESP, COP} state_t;

  // Storage. PLRU node n (heap order, root = 1) lives in bit n-1; a bit of 1
  // means the right subtree is the least recently used side.
  logic [TW-1:0]   tag_arr   [SETS][WAYS];
  logic [WAYS-1:0] valid_arr [SETS];
  logic [PW-1:0]   plru_arr  [SETS];
  logic [31:0]     data_arr  [SETS][WAYS][WPL];

  state_t                 state, state_nxt;
  logic [LW-1:0]          victim_q;
  logic [WW-1:0]          cnt;
  logic [31:0]            resp_q;
  logic                   cop_type_q;
  logic [INDEX_WIDTH-1:0] cop_idx_q;
  logic [TW-1:0]          cop_tag_q;
  logic [LW-1:0]          cop_way_q;

  logic [INDEX_WIDTH-1:0] idx;
  logic [TW-1:0]          tag;
  logic [WW-1:0]          woff;
  logic [LW-1:0]          cop_way;
  logic [WAYS-1:0]        hit_vec, cop_hit_vec;
  logic                   hit;
  logic [LW-1:0]          hit_way, inv_way, plru_way;
  logic                   inv_found;
  logic                   unused_cop_off;

  assign idx     = pc[OFFSET_WIDTH +: INDEX_WIDTH];
  assign tag     = pc[31 -: TW];
  assign woff    = pc[2 +: WW];
  assign cop_way = (WAYS > 1) ? cop_addr[OFFSET_WIDTH+INDEX_WIDTH +: LW] : '0;
  assign hit     = |hit_vec;
  assign unused_cop_off = ^cop_addr[OFFSET_WIDTH-1:0];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way_cmp #(.TW(TW)) u_cmp (
      .valid(valid_arr[idx][w]), .tag_stored(tag_arr[idx][w]),
      .tag_in(tag), .hit(hit_vec[w]));
    icache_way_cmp #(.TW(TW)) u_cop_cmp (
      .valid(valid_arr[cop_idx_q][w]), .tag_stored(tag_arr[cop_idx_q][w]),
      .tag_in(cop_tag_q), .hit(cop_hit_vec[w]));
  end

  // Point every node on the accessed way's path away from that way.
  function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] bits, input logic [LW-1:0] way);
    logic [PW-1:0] nb;
    int node;
    nb = bits;
    node = 1;
    for (int l = 0; l < LVL; l++) begin
      for (int n = 1; n < WAYS; n++) if (n == node) nb[n-1] = ~way[LVL-1-l];
      node = 2 * node + int'(way[LVL-1-l]);
    end
    return nb;
  endfunction

  // Lowest matching way and lowest invalid way of the fetch set.
  always_comb begin
    hit_way   = '0;
    inv_way   = '0;
    inv_found = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = LW'(w);
      if (!valid_arr[idx][w]) begin
        inv_found = 1'b1;
        inv_way   = LW'(w);
      end
    end
  end

  // Walk the PLRU tree toward the least recently used leaf.
  always_comb begin : p_plru_victim
    int  node;
    logic b;
    node = 1;
    for (int l = 0; l < LVL; l++) begin
      b = 1'b0;
      for (int n = 1; n < WAYS; n++) if (n == node) b = plru_arr[idx][n-1];
      node = 2 * node + int'(b);
    end
    plru_way = LW'(node - WAYS);
  end

  // Next state and all bus/requester outputs; reset forces the bus idle.
  always_comb begin
    state_nxt  = state;
    stall      = 1'b0;
    inst_rdata = '0;
    arvalid    = 1'b0;
    araddr     = '0;
    arlen      = '0;
    rready     = 1'b0;
    case (state)
      LOOKUP: begin
        if (cop_en) begin
          stall     = 1'b1;
          state_nxt = COP;
        end else if (inst_en) begin
          if (no_cache) begin
            stall     = 1'b1;
            state_nxt = UNC_AR;
          end else if (hit) begin
            inst_rdata = data_arr[idx][hit_way][woff];
          end else begin
            stall     = 1'b1;
            state_nxt = REFILL_AR;
          end
        end
      end
      REFILL_AR: begin
        stall   = 1'b1;
        arvalid = 1'b1;
        araddr  = {pc[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
        arlen   = 8'(WPL - 1);
        if (arready) state_nxt = REFILL_R;
      end
      REFILL_R: begin
        stall  = 1'b1;
        rready = 1'b1;
        if (rvalid && rlast) state_nxt = RESP;
      end
      UNC_AR: begin
        stall   = 1'b1;
        arvalid = 1'b1;
        araddr  = pc;
        if (arready) state_nxt = UNC_R;
      end
      UNC_R: begin
        stall  = 1'b1;
        rready = 1'b1;
        if (rvalid && rlast) state_nxt = RESP;
      end
      RESP: begin
        inst_rdata = resp_q;
        state_nxt  = LOOKUP;
      end
      COP: begin
        stall     = 1'b1;
        state_nxt = LOOKUP;
      end
      default: state_nxt = LOOKUP;
    endcase
    if (rst) begin
      stall      = 1'b0;
      inst_rdata = '0;
      arvalid    = 1'b0;
      araddr     = '0;
      arlen      = '0;
      rready     = 1'b0;
    end
  end

  // Control state, valid/PLRU bookkeeping, refill counter and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOOKUP;
      victim_q   <= '0;
      cnt        <= '0;
      resp_q     <= '0;
      cop_type_q <= 1'b0;
      cop_idx_q  <= '0;
      cop_tag_q  <= '0;
      cop_way_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_arr[s] <= '0;
        plru_arr[s]  <= '0;
      end
    end else begin
      state <= state_nxt;
      case (state)
        LOOKUP: begin
          if (cop_en) begin
            cop_type_q <= cop_type;
            cop_idx_q  <= cop_addr[OFFSET_WIDTH +: INDEX_WIDTH];
            cop_tag_q  <= cop_addr[31 -: TW];
            cop_way_q  <= cop_way;
          end else if (inst_en && !no_cache) begin
            if (hit) plru_arr[idx] <= plru_touch(plru_arr[idx], hit_way);
            else     victim_q      <= inv_found ? inv_way : plru_way;
          end
        end
        REFILL_R: begin
          if (rvalid) begin
            if (cnt == woff) resp_q <= rdata;
            cnt <= cnt + 1'b1;
            if (rlast) begin
              cnt                      <= '0;
              valid_arr[idx][victim_q] <= 1'b1;
              plru_arr[idx]            <= plru_touch(plru_arr[idx], victim_q);
            end
          end
        end
        UNC_R: if (rvalid && rlast) resp_q <= rdata;
        COP: begin
          if (cop_type_q) valid_arr[cop_idx_q]            <= valid_arr[cop_idx_q] & ~cop_hit_vec;
          else            valid_arr[cop_idx_q][cop_way_q] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Line data and tag writes during refill; contents are not reset.
  always_ff @(posedge clk) begin
    if (!rst && state == REFILL_R && rvalid) begin
      data_arr[idx][victim_q][cnt] <= rdata;
      if (rlast) tag_arr[idx][victim_q] <= tag;
    end
  end
endmodule

// File: tb/tb_icache_param.sv
// Randomised bench for icache_param against a line-address cache model with
// tree-PLRU replacement, plus directed cold-miss, PLRU, uncached, invalidate,
// backpressure and mid-refill reset scenarios.
module tb_icache_param;
  localparam int IW = 7, OW = 5, WAYS = 4, LOG = 2;
  localparam int SETS = 1 << IW, WPL = 1 << (OW - 2);
  localparam logic [31:0] LMASK = ~32'(WPL * 4 - 1);

  logic        clk = 1'b0, rst = 1'b1;
  logic        inst_en, no_cache, cop_en, cop_type, arready, rvalid, rlast;
  logic [31:0] pc, cop_addr, rdata;
  logic [31:0] inst_rdata, araddr;
  logic [7:0]  arlen;
  logic        stall, arvalid, rready;

  always #5 clk = ~clk;

  icache_param #(.INDEX_WIDTH(IW), .OFFSET_WIDTH(OW), .WAYS(WAYS)) dut (
    .clk(clk), .rst(rst), .inst_en(inst_en), .pc(pc), .no_cache(no_cache),
    .cop_en(cop_en), .cop_type(cop_type), .cop_addr(cop_addr),
    .inst_rdata(inst_rdata), .stall(stall), .araddr(araddr), .arlen(arlen),
    .arvalid(arvalid), .arready(arready), .rdata(rdata), .rvalid(rvalid),
    .rlast(rlast), .rready(rready));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: per set, each way holds a line address, and the PLRU
  // tree is kept as node flags m_p[s][1..WAYS-1] (1 = right side is older).
  bit          m_v [SETS][WAYS];
  logic [31:0] m_line [SETS][WAYS];
  logic [31:0] m_d [SETS][WAYS][WPL];
  bit          m_p [SETS][WAYS];

  bit          fixed_en = 1'b0;
  logic [31:0] fixed_base = '0;

  function automatic logic [31:0] beat_data(input logic [31:0] a, input int i);
    logic [31:0] x;
    x = a + 32'(4 * i);
    return fixed_en ? fixed_base + 32'(i) : (x * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_v[s][w] = 1'b0;
        m_p[s][w] = 1'b0;
      end
  endfunction

  function automatic bit m_lookup(input logic [31:0] line, input int s, output int w);
    w = 0;
    for (int i = 0; i < WAYS; i++)
      if (m_v[s][i] && m_line[s][i] == line) begin
        w = i;
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic void m_touch(input int s, input int w);
    for (int l = 0; l < LOG; l++)
      m_p[s][(1 << l) + (w >> (LOG - l))] = ((w >> (LOG - 1 - l)) & 1) == 0;
  endfunction

  function automatic int m_victim(input int s);
    int lo, span, node;
    for (int w = 0; w < WAYS; w++) if (!m_v[s][w]) return w;
    lo = 0; span = WAYS; node = 1;
    while (span > 1) begin
      span = span / 2;
      if (m_p[s][node]) begin lo += span; node = 2 * node + 1; end
      else node = 2 * node;
    end
    return lo;
  endfunction

  // Issue one fetch and act as the AXI slave until stall drops. rst_beat >= 0
  // asserts reset once that many refill beats have been consumed.
  task automatic fetch(input logic [31:0] a, input bit nc, input int dly, input bit gap,
                       input int rst_beat, output int stalls, output logic [31:0] rd,
                       output int bursts, output logic [31:0] ar_a, output logic [7:0] ar_l,
                       output int beats);
    bit ar_seen = 0, ar_acc = 0, tog = 0, done = 0, aborted = 0;
    int wt = 0, nb = 0;
    stalls = 0; bursts = 0; beats = 0; rd = '0; ar_a = '0; ar_l = '0;
    inst_en = 1'b1; pc = a; no_cache = nc;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge clk);
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
      if (rst_beat >= 0 && beats == rst_beat) begin
        rst = 1'b1;
        #1;
        chk("rst_mid_stall", stall, 0);
        chk("rst_mid_arvalid", arvalid, 0);
        chk("rst_mid_rready", rready, 0);
        chk("rst_mid_araddr", araddr, 0);
        @(posedge clk); #1;
        rst = 1'b0; inst_en = 1'b0;
        done = 1; aborted = 1;
      end else if (!stall) begin
        rd = inst_rdata;
        done = 1;
      end else begin
        stalls++;
        if (arvalid) begin
          if (!ar_seen || ar_acc) begin
            ar_seen = 1; ar_acc = 0; wt = 0;
            ar_a = araddr; ar_l = arlen; bursts++;
          end else begin
            chk("ar_addr_stable", araddr, ar_a);
            chk("ar_len_stable", arlen, ar_l);
          end
          if (wt >= dly) begin
            arready = 1'b1; ar_acc = 1; nb = int'(arlen) + 1;
          end
          wt++;
        end
        if (rready && ar_acc && beats < nb && !(gap && tog)) begin
          rvalid = 1'b1; rdata = beat_data(ar_a, beats); rlast = (beats == nb - 1);
          beats++;
        end else if (!rready && $urandom_range(0, 3) == 0) begin
          rvalid = 1'b1; rdata = 32'hBAD0BAD0; rlast = 1'b1;   // must be ignored
        end
        tog = ~tog;
      end
    end
    if (!done) chk("fetch_timeout", 0, 1);
    if (!aborted) begin
      @(posedge clk); #1;
      inst_en = 1'b0;
    end
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
  endtask

  // Fetch checked against the model; the model is updated afterwards.
  task automatic access(input logic [31:0] a, input bit nc, input int dly, input bit gap,
                        output bit was_hit, output logic [31:0] rd);
    int st, bu, be, s, w, wo, v;
    logic [31:0] ara, line, exp_a;
    logic [7:0] arl;
    bit h;
    line = a & LMASK;
    s  = int'(a[OW +: IW]);
    wo = int'(a[2 +: OW - 2]);
    h  = !nc && m_lookup(line, s, w);
    fetch(a, nc, dly, gap, -1, st, rd, bu, ara, arl, be);
    was_hit = (st == 0);
    chk("hit_vs_model", was_hit, h);
    if (h) begin
      chk("hit_data", rd, m_d[s][w][wo]);
      m_touch(s, w);
    end else begin
      exp_a = nc ? a : line;
      chk("bursts", bu, 1);
      chk("araddr", ara, exp_a);
      chk("arlen", arl, nc ? 0 : WPL - 1);
      chk("beats", be, nc ? 1 : WPL);
      chk("miss_data", rd, beat_data(exp_a, nc ? 0 : wo));
      if (!nc) begin
        v = m_victim(s);
        m_v[s][v] = 1'b1;
        m_line[s][v] = line;
        for (int i = 0; i < WPL; i++) m_d[s][v][i] = beat_data(line, i);
        m_touch(s, v);
      end
    end
  endtask

  // Maintenance op; inst_en is raised too, so cop_en must win the cycle.
  task automatic cop(input bit ty, input logic [31:0] a);
    int s, w;
    cop_en = 1'b1; cop_type = ty; cop_addr = a;
    inst_en = 1'b1; pc = a; no_cache = 1'b0;
    @(negedge clk);
    chk("cop_accept_stall", stall, 1);
    chk("cop_accept_arvalid", arvalid, 0);
    @(posedge clk); #1;
    cop_en = 1'b0; inst_en = 1'b0;
    @(negedge clk);
    chk("cop_stall", stall, 1);
    chk("cop_arvalid", arvalid, 0);
    @(posedge clk); #1;
    s = int'(a[OW +: IW]);
    if (!ty) m_v[s][int'(a[OW + IW +: LOG])] = 1'b0;
    else if (m_lookup(a & LMASK, s, w)) m_v[s][w] = 1'b0;
  endtask

  task automatic idle();
    inst_en = 1'b0;
    @(negedge clk);
    chk("idle_stall", stall, 0);
    chk("idle_arvalid", arvalid, 0);
    chk("idle_rready", rready, 0);
    chk("idle_araddr", araddr, 0);
    chk("idle_arlen", arlen, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit h;
    logic [31:0] rd, a;
    int st, bu, be, w, r;
    logic [31:0] ara;
    logic [7:0] arl;
    no_cache = 0; cop_en = 0; cop_type = 0; cop_addr = 0;
    arready = 0; rdata = 0; rvalid = 0; rlast = 0;
    model_reset();
    rst = 1'b1; inst_en = 1'b1; pc = 32'h0000_1014;
    repeat (3) begin
      @(negedge clk);
      chk("rst_stall", stall, 0);
      chk("rst_arvalid", arvalid, 0);
      chk("rst_rready", rready, 0);
      chk("rst_araddr", araddr, 0);
      chk("rst_arlen", arlen, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; inst_en = 1'b0;
    idle();

    // cold miss then zero-stall hit
    fixed_en = 1; fixed_base = 32'hA0;
    access(32'h0000_1014, 0, 0, 0, h, rd);
    chk("cold_miss", h, 0);
    chk("cold_data", rd, 32'hA5);
    fixed_en = 0;
    access(32'h0000_1014, 0, 0, 0, h, rd);
    chk("refetch_hit", h, 1);
    chk("refetch_data", rd, 32'hA5);

    // slow address handshake and gapped data beats
    access(32'h0000_2008, 0, 5, 1, h, rd);
    chk("slow_miss", h, 0);
    access(32'h0000_201C, 0, 0, 0, h, rd);
    chk("slow_line_hit", h, 1);

    // five tags in one set: the fifth fill evicts the first
    for (int t = 1; t <= 5; t++) access((32'(t) << 12) | (32'd3 << 5), 0, 0, 0, h, rd);
    access((32'd1 << 12) | (32'd3 << 5), 0, 0, 0, h, rd);
    chk("plru_evict_first", h, 0);

    // uncached fetch, then cached fetch of the same pc still misses
    fixed_en = 1; fixed_base = 32'hDEADBEEF;
    access(32'h1FC0_0008, 1, 1, 0, h, rd);
    chk("unc_data", rd, 32'hDEADBEEF);
    fixed_en = 0;
    access(32'h1FC0_0008, 0, 0, 0, h, rd);
    chk("unc_not_cached", h, 0);

    // hit-invalidate resident / absent, index-invalidate
    cop(1'b1, 32'h0000_1014);
    access(32'h0000_1014, 0, 0, 0, h, rd);
    chk("hitinv_miss", h, 0);
    cop(1'b1, 32'h00F0_1014);
    access(32'h0000_1018, 0, 0, 0, h, rd);
    chk("hitinv_absent_hit", h, 1);
    void'(m_lookup(32'h0000_1000, 0, w));
    cop(1'b0, 32'(w) << 12);
    access(32'h0000_1014, 0, 0, 0, h, rd);
    chk("idxinv_miss", h, 0);

    // reset after three refill beats, then the line must be fetched afresh
    fetch(32'h0000_3004, 0, 0, 0, 3, st, rd, bu, ara, arl, be);
    model_reset();
    idle();
    access(32'h0000_3004, 0, 0, 0, h, rd);
    chk("post_rst_miss", h, 0);

    // random mix
    for (int k = 0; k < 250; k++) begin
      r = $urandom_range(0, 99);
      a = (32'($urandom_range(1, 6)) << 12) | (32'($urandom_range(1, 2)) << 5)
        | (32'($urandom_range(0, 7)) << 2);
      if (r < 65)      access(a, 0, $urandom_range(0, 3), 1'($urandom_range(0, 1)), h, rd);
      else if (r < 75) access(a, 1, $urandom_range(0, 3), 1'($urandom_range(0, 1)), h, rd);
      else if (r < 92) cop(1'($urandom_range(0, 1)), a);
      else             idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/icache_param.md
ICACHE_PARAM -- requirements
Module: icache_param

Interface
REQ-001 INDEX_WIDTH, default 7, set-index bits; sets = 2^INDEX_WIDTH.
REQ-002 OFFSET_WIDTH, default 5, line-offset bits, legal range 3..6; words per line W = 2^(OFFSET_WIDTH-2).
REQ-003 WAYS, default 4, associativity, power of two in 1..8; TAG_WIDTH = 32-INDEX_WIDTH-OFFSET_WIDTH.
REQ-004 Clock and reset: clk (input, 1 bit) is the clock, and rst (input, 1 bit) is the synchronous, active-high reset.
REQ-005 inst_en input 1: fetch request; pc input 32: fetch address, held stable by the requester while stall=1.
REQ-006 no_cache input 1: fetch is uncached; sampled with inst_en.
REQ-007 cop_en input 1, cop_type input 1 (0 index-invalidate, 1 hit-invalidate), cop_addr input 32: cache-maintenance request.
REQ-008 inst_rdata output 32 fetched word; stall output 1 request not complete.
REQ-009 araddr output 32, arlen output 8, arvalid output 1, arready input 1: AXI read address channel (INCR burst).
REQ-010 rdata input 32, rvalid input 1, rlast input 1, rready output 1: AXI read data channel.

Function
REQ-011 Tag, valid, PLRU and data storage are flop arrays; lookup is combinational on pc in the same cycle.
REQ-012 States: LOOKUP, REFILL_AR, REFILL_R, UNC_AR, UNC_R, RESP, COP.
REQ-013 LOOKUP hit (inst_en, ~no_cache, valid and tag match in any way, no cop_en): stall=0, inst_rdata=hit word in that cycle, PLRU updated; hit latency 0 cycles.
REQ-014 LOOKUP miss: stall=1 and next state REFILL_AR, latching the victim way.
REQ-015 Uncached fetch: stall=1 and next state UNC_AR; no array is read for data and none is written.
REQ-016 Victim choice: the lowest-numbered invalid way, or the tree-PLRU way (WAYS-1 bits per set) if all ways are valid; for WAYS=1 the victim is way 0.
REQ-017 PLRU update on hit or refill completion: the tree nodes on the accessed path point away from the accessed way.
REQ-018 REFILL_AR: arvalid=1, araddr = pc with the offset field zeroed, arlen = W-1; it advances to REFILL_R on arvalid&arready.
REQ-019 arvalid, araddr and arlen hold stable until the handshake.
REQ-020 REFILL_R: rready=1; each rvalid beat writes word cnt of the victim line, and cnt increments from 0 and wraps modulo W.
REQ-021 In REFILL_R, the beat with cnt == pc word offset is captured into the response register.
REQ-022 When the rlast beat is accepted, tag and valid are written for the victim way and the state moves to RESP.
REQ-023 UNC_AR: arvalid=1, araddr=pc, arlen=0. UNC_R: rready=1; the rlast beat is captured into the response register and the state moves to RESP.
REQ-024 RESP (one cycle): stall=0, inst_rdata = response register, return to LOOKUP; the requester advances pc on this cycle.
REQ-025 cop_en is accepted only in LOOKUP and has priority over inst_en that cycle; stall=1 and the next state is COP.
REQ-026 COP, index-invalidate: clears valid of way cop_addr[OFFSET_WIDTH+INDEX_WIDTH +: log2(WAYS)] at set cop_addr index; for WAYS=1 it clears way 0.
REQ-027 COP, hit-invalidate: clears valid of the matching way only, and a miss is a no-op.
REQ-028 COP lasts one cycle, then LOOKUP; stall=1 during COP.
REQ-029 cop_en asserted outside LOOKUP is ignored; the requester holds it.
REQ-030 inst_en=0 in LOOKUP: stall=0, and no state, PLRU or AXI change.
REQ-031 At most one AXI transaction is outstanding; arvalid=0 in every state except *_AR, and rready=0 in every state except *_R.
REQ-032 rvalid beats arriving while rready=0 are not consumed.
REQ-033 A refill is never aborted; a change of pc during stall is a requester protocol error with undefined behaviour.

Reset
REQ-034 On rst: state LOOKUP; all valid bits 0; all PLRU bits 0; cnt 0; response register 0.
REQ-035 During and immediately after rst: arvalid=0, rready=0, stall=0, araddr=0, arlen=0; data array contents are not reset.
REQ-036 rst mid-refill discards the partial line (valid stays 0), and the external arbiter is reset in the same cycle.

Verification
REQ-037 Cold miss, defaults: pc=0x0000_1014 -> araddr=0x0000_1000, arlen=7; 8 beats 0xA0..0xA7 -> RESP inst_rdata=0xA5; refetch of 0x1014 hits with 0 stall cycles.
REQ-038 PLRU, WAYS=4: fill 5 lines with the same index and different tags, touching ways 0-3 in order -> the fifth fill evicts way 0; re-access of the first tag misses.
REQ-039 Uncached: no_cache=1, pc=0x1FC0_0008 -> araddr=0x1FC0_0008, arlen=0; rdata=0xDEADBEEF -> inst_rdata=0xDEADBEEF in RESP; a cached refetch of the same pc misses.
REQ-040 Hit-invalidate of a resident line -> the next fetch misses; hit-invalidate of an absent line -> no change and the resident line still hits.
REQ-041 arready held 0 for 5 cycles, rvalid gapped every other cycle -> arvalid, araddr and arlen stable, stall=1 throughout, and the line is correct.
REQ-042 rst asserted after beat 3 of a refill -> the next fetch of the same pc misses and a new burst is issued from word 0.
